core_sequencer: RTL

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Job sequencer for the attention core: key load, query load, key preload, execute,
// pipeline drain, then psum readout with downstream backpressure.
module core_sequencer #(
  parameter int col       = 8,
  parameter int pr        = 8,
  parameter int drain_len = col + pr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  num_q,
  input  logic        out_ready,
  output logic [16:0] inst,
  output logic        s_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, KLOAD, QLOAD, KPRE, EXEC, DRAIN, READOUT, DONE
  } state_t;

  localparam logic [4:0] COL_LAST   = 5'(col - 1);
  localparam logic [4:0] DRAIN_LAST = 5'(drain_len - 1);

  state_t      state, next_state;
  logic [4:0]  cnt, next_cnt;
  logic [4:0]  nq, next_nq;
  logic [16:0] next_inst;
  logic [4:0]  nq_last;
  logic        start_ok;
  logic        read_now;

  assign nq_last  = nq - 5'd1;
  assign start_ok = start && (num_q != 5'd0) && (num_q <= 5'd16);
  assign read_now = inst[10];

  // Outputs are decoded from the next state so the registered inst lines up with the
  // state it belongs to; the readout read decision therefore uses out_ready as sampled
  // at the edge that opens the cycle.
  always_comb begin
    next_state = state;
    next_cnt   = cnt + 5'd1;
    next_nq    = nq;
    next_inst  = '0;

    case (state)
      IDLE: begin
        next_cnt = 5'd0;
        if (start_ok) begin
          next_state = KLOAD;
          next_nq    = num_q;
        end
      end
      KLOAD:
        if (cnt == COL_LAST) begin
          next_state = QLOAD;
          next_cnt   = 5'd0;
        end
      QLOAD:
        if (cnt == nq_last) begin
          next_state = KPRE;
          next_cnt   = 5'd0;
        end
      KPRE:
        if (cnt == COL_LAST) begin
          next_state = EXEC;
          next_cnt   = 5'd0;
        end
      EXEC:
        if (cnt == nq_last) begin
          next_state = DRAIN;
          next_cnt   = 5'd0;
        end
      DRAIN:
        if (cnt == DRAIN_LAST) begin
          next_state = READOUT;
          next_cnt   = 5'd0;
        end
      READOUT: begin
        // In readout the counter tracks reads issued, not elapsed cycles.
        next_cnt = cnt + {4'd0, read_now};
        if (read_now && (cnt == nq_last)) begin
          next_state = DONE;
          next_cnt   = 5'd0;
        end
      end
      DONE: begin
        next_state = IDLE;
        next_cnt   = 5'd0;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 5'd0;
      end
    endcase

    case (next_state)
      KLOAD: begin
        next_inst[4]   = 1'b1;
        next_inst[3:0] = next_cnt[3:0];
      end
      QLOAD: begin
        next_inst[6]   = 1'b1;
        next_inst[3:0] = next_cnt[3:0];
      end
      KPRE: begin
        next_inst[5]   = 1'b1;
        next_inst[8]   = 1'b1;
        next_inst[3:0] = next_cnt[3:0];
      end
      EXEC: begin
        next_inst[7]   = 1'b1;
        next_inst[9]   = 1'b1;
        next_inst[3:0] = next_cnt[3:0];
      end
      READOUT:
        if (out_ready) begin
          next_inst[10]    = 1'b1;
          next_inst[11]    = 1'b1;
          next_inst[15:12] = next_cnt[3:0];
        end
      default: next_inst = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      nq      <= 5'd0;
      inst    <= '0;
      s_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      nq      <= next_nq;
      inst    <= next_inst;
      s_valid <= read_now;
      busy    <= (next_state != IDLE);
      done    <= (next_state == DONE);
    end
  end

endmodule
